// File: rtl/barrido_display_if.sv
// barrido_display_if: load/BCD inputs and segment/anode outputs of the two-digit scan controller.
interface barrido_display_if;
    logic       en, load, load_ack, En_decena;
    logic [3:0] bcd_u, bcd_d;
    logic [6:0] cSegU, cSegD;
    logic [1:0] An;
    modport master(output en, load, bcd_u, bcd_d, input load_ack, cSegU, cSegD, An, En_decena);
    modport slave(input en, load, bcd_u, bcd_d, output load_ack, cSegU, cSegD, An, En_decena);
endinterface

// File: rtl/barrido_display.sv
// barrido_display: two-digit seven-segment scan controller with guard slots and latched BCD decode.
module barrido_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16,
    parameter int BLANK_LZ    = 1
) (
    input logic clk,
    input logic rst,
    barrido_display_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV + GUARD + 1);
    typedef enum logic [1:0] {S_UNI, S_G1, S_DEC, S_G2} state_t;
    state_t state_q, state_d, state_nxt;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0] seg_u_q, seg_u_d, seg_d_q, seg_d_d;
    logic ack_q, ack_d, done;

    function automatic logic [6:0] dec7(input logic [3:0] b);
        case (b)
            4'd0: return 7'h01;
            4'd1: return 7'h4F;
            4'd2: return 7'h12;
            4'd3: return 7'h06;
            4'd4: return 7'h4C;
            4'd5: return 7'h24;
            4'd6: return 7'h20;
            4'd7: return 7'h0F;
            4'd8: return 7'h00;
            4'd9: return 7'h04;
            default: return 7'h7E;
        endcase
    endfunction

    always_comb begin
        done = (state_q == S_UNI || state_q == S_DEC) ? (int'(cnt_q) == REFRESH_DIV - 1)
                                                      : (int'(cnt_q) == GUARD - 1);
        state_nxt = state_q == S_UNI ? (GUARD > 0 ? S_G1 : S_DEC) :
                    state_q == S_G1  ? S_DEC :
                    state_q == S_DEC ? (GUARD > 0 ? S_G2 : S_UNI) : S_UNI;
        state_d = (bus.en && done) ? state_nxt : state_q;
        cnt_d   = !bus.en ? cnt_q : done ? '0 : cnt_q + CW'(1);
        ack_d   = bus.load;
        seg_u_d = bus.load ? dec7(bus.bcd_u) : seg_u_q;
        // a zero tens digit is blanked rather than shown as a leading 0
        seg_d_d = bus.load ? ((BLANK_LZ != 0 && bus.bcd_d == 4'd0) ? 7'h7F : dec7(bus.bcd_d)) : seg_d_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_UNI;
            cnt_q   <= '0;
            seg_u_q <= 7'h7F;
            seg_d_q <= 7'h7F;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seg_u_q <= seg_u_d;
            seg_d_q <= seg_d_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.An        = !bus.en ? 2'b11 : state_q == S_UNI ? 2'b10 : state_q == S_DEC ? 2'b01 : 2'b11;
    assign bus.En_decena = !(bus.en && state_q == S_DEC);
    assign bus.cSegU     = seg_u_q;
    assign bus.cSegD     = seg_d_q;
    assign bus.load_ack  = ack_q;
endmodule
